// File: rtl/bram_bank_arbiter_pkg.sv
// Shared constants and types for the BRAM bank arbiter.
//   SELECT_W  : address MSBs that pick a bank
//   NUM_BANKS : bank count (2**SELECT_W)
//   DATA_W    : bank data width
//   state_t   : arbiter FSM encodings (INIT zero-fill / READY arbitration)
package bram_bank_arbiter_pkg;

    localparam int SELECT_W  = 2;
    localparam int NUM_BANKS = 1 << SELECT_W;
    localparam int DATA_W    = 8;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Every SELECT_W-bit value names a real bank, so no range check is needed.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [SELECT_W-1:0] b);
        logic [NUM_BANKS-1:0] oh;
        oh    = '0;
        oh[b] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bram_bank_arbiter_if.sv
// Bus bundle between the requesters/banks and the arbiter.
//   Request side : req, req_we, req_addr, req_wdata (packed per requester), gnt
//   Bank side    : bank_en, bank_we, bank_addr, bank_wdata
//   Return side  : sel (output mux select), rvalid, rid, init_done
// slave  = the arbiter, master = requester/bank environment.
interface bram_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int BANK_AW = 10
);
    import bram_bank_arbiter_pkg::*;

    localparam int AW_FULL = BANK_AW + SELECT_W;
    localparam int IDW     = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         req_we;
    logic [NUM_REQ*AW_FULL-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_wdata;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_BANKS-1:0]       bank_en;
    logic [NUM_BANKS-1:0]       bank_we;
    logic [BANK_AW-1:0]         bank_addr;
    logic [DATA_W-1:0]          bank_wdata;
    logic [SELECT_W-1:0]        sel;
    logic                       rvalid;
    logic [IDW-1:0]             rid;
    logic                       init_done;

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, bank_en, bank_we, bank_addr, bank_wdata, sel, rvalid, rid, init_done
    );

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, bank_en, bank_we, bank_addr, bank_wdata, sel, rvalid, rid, init_done
    );

endinterface

// File: rtl/bram_bank_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping NUM_REQ-1 -> 0.
//   req     : request vector
//   ptr     : highest-priority requester index
//   gnt     : one-hot grant (0 when no request)
//   gnt_idx : index of the granted requester
//   gnt_any : some request was granted
module bram_bank_arbiter_rr #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_any
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Extra bit keeps ptr+k from overflowing before the wrap.
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            cand = sum[IDW-1:0];
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bram_bank_arbiter.sv
// Shares four 8-bit BRAM banks among NUM_REQ requesters, one access per cycle,
// round-robin. After reset (INIT_EN=1) every bank word is zero-filled before
// any request is granted. Read returns are tagged with the requester id and
// the bank select is delayed to line up with the BRAM read latency.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/bank/return bundle (slave side)
module bram_bank_arbiter
    import bram_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int BANK_AW  = 10,
    parameter int READ_LAT = 1,
    parameter int INIT_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    bram_bank_arbiter_if.slave bus
);

    localparam int AW_FULL = BANK_AW + SELECT_W;
    localparam int IDW     = $clog2(NUM_REQ);
    localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_READY;

    state_t               state_q, state_d;
    logic [BANK_AW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;
    logic [NUM_BANKS-1:0] bank_we_q, bank_we_d;
    logic [BANK_AW-1:0]   bank_addr_q, bank_addr_d;
    logic [DATA_W-1:0]    bank_wdata_q, bank_wdata_d;
    logic                 init_done_q, init_done_d;

    // Return pipeline; stage READ_LAT is the visible output stage.
    logic                pv_q   [READ_LAT+1];
    logic                pv_d   [READ_LAT+1];
    logic [IDW-1:0]      pid_q  [READ_LAT+1];
    logic [IDW-1:0]      pid_d  [READ_LAT+1];
    logic [SELECT_W-1:0] psel_q [READ_LAT+1];
    logic [SELECT_W-1:0] psel_d [READ_LAT+1];

    logic [AW_FULL-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.req_addr[gi*AW_FULL +: AW_FULL];
        assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
    end

    // Arbitration
    logic               arb_en, accept, gnt_any_raw;
    logic [NUM_REQ-1:0] gnt_raw, gnt;
    logic [IDW-1:0]     gnt_idx;

    bram_bank_arbiter_rr #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt     (gnt_raw),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any_raw)
    );

    // Grants are suppressed during zero-fill and in the reset cycle.
    assign arb_en  = (state_q == ST_READY) && !rst;
    assign gnt     = arb_en ? gnt_raw : '0;
    assign accept  = arb_en && gnt_any_raw;
    assign bus.gnt = gnt;

    // Fields of the granted requester (AND-OR over the one-hot grant).
    logic [AW_FULL-1:0]  g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic                g_we;
    logic [SELECT_W-1:0] g_bank;
    logic                rd_issue;

    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                g_addr  = g_addr | addr_arr[i];
                g_wdata = g_wdata | wdata_arr[i];
                g_we    = g_we | bus.req_we[i];
            end
        end
    end

    assign g_bank   = g_addr[AW_FULL-1 -: SELECT_W];
    assign rd_issue = accept && !g_we;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= RST_STATE;
        else     state_q <= state_d;
    end

    // FSM: next state -- leave INIT once the last word has been issued.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && fill_cnt_q == '1) begin
            state_d = ST_READY;
        end
    end

    // FSM: outputs / datapath next values
    always_comb begin
        bank_en_d    = '0;
        bank_we_d    = '0;
        bank_addr_d  = bank_addr_q;
        bank_wdata_d = bank_wdata_q;
        fill_cnt_d   = fill_cnt_q;
        ptr_d        = ptr_q;
        init_done_d  = (state_q == ST_READY);
        if (state_q == ST_INIT) begin
            bank_en_d    = '1;
            bank_we_d    = '1;
            bank_addr_d  = fill_cnt_q;
            bank_wdata_d = '0;
            fill_cnt_d   = fill_cnt_q + BANK_AW'(1);
        end else if (accept) begin
            bank_en_d    = bank_onehot(g_bank);
            bank_we_d    = g_we ? bank_onehot(g_bank) : '0;
            bank_addr_d  = g_addr[BANK_AW-1:0];
            bank_wdata_d = g_wdata;
            ptr_d        = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
        end

        // id/select registers only move with a valid entry, so the outputs
        // hold their last value while rvalid is low.
        pv_d[0]   = rd_issue;
        pid_d[0]  = rd_issue ? gnt_idx : pid_q[0];
        psel_d[0] = rd_issue ? g_bank  : psel_q[0];
        for (int j = 1; j <= READ_LAT; j++) begin
            pv_d[j]   = pv_q[j-1];
            pid_d[j]  = pv_q[j-1] ? pid_q[j-1]  : pid_q[j];
            psel_d[j] = pv_q[j-1] ? psel_q[j-1] : psel_q[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt_q   <= '0;
            ptr_q        <= '0;
            bank_en_q    <= '0;
            bank_we_q    <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            init_done_q  <= 1'b0;
            for (int j = 0; j <= READ_LAT; j++) begin
                pv_q[j]   <= 1'b0;
                pid_q[j]  <= '0;
                psel_q[j] <= '0;
            end
        end else begin
            fill_cnt_q   <= fill_cnt_d;
            ptr_q        <= ptr_d;
            bank_en_q    <= bank_en_d;
            bank_we_q    <= bank_we_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
            init_done_q  <= init_done_d;
            for (int j = 0; j <= READ_LAT; j++) begin
                pv_q[j]   <= pv_d[j];
                pid_q[j]  <= pid_d[j];
                psel_q[j] <= psel_d[j];
            end
        end
    end

    assign bus.bank_en    = bank_en_q;
    assign bus.bank_we    = bank_we_q;
    assign bus.bank_addr  = bank_addr_q;
    assign bus.bank_wdata = bank_wdata_q;
    assign bus.rvalid     = pv_q[READ_LAT];
    assign bus.rid        = pid_q[READ_LAT];
    assign bus.sel        = psel_q[READ_LAT];
    assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_bram_bank_arbiter.sv
// Directed bench: two arbiters (READ_LAT=1 and READ_LAT=2) share one stimulus
// stream; each drives its own behavioural four-bank BRAM and output mux.
module tb_bram_bank_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 4;
    localparam int AWF = AW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]     req;
    logic [NR-1:0]     req_we;
    logic [NR*AWF-1:0] req_addr;
    logic [NR*8-1:0]   req_wdata;

    bram_bank_arbiter_if #(.NUM_REQ(NR), .BANK_AW(AW)) bus1 ();
    bram_bank_arbiter_if #(.NUM_REQ(NR), .BANK_AW(AW)) bus2 ();

    assign bus1.req = req;  assign bus1.req_we = req_we;
    assign bus1.req_addr = req_addr;  assign bus1.req_wdata = req_wdata;
    assign bus2.req = req;  assign bus2.req_we = req_we;
    assign bus2.req_addr = req_addr;  assign bus2.req_wdata = req_wdata;

    bram_bank_arbiter #(.NUM_REQ(NR), .BANK_AW(AW), .READ_LAT(1), .INIT_EN(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    bram_bank_arbiter #(.NUM_REQ(NR), .BANK_AW(AW), .READ_LAT(2), .INIT_EN(1)) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    // Behavioural banks: write-first, one registered read stage (plus an
    // output register for the latency-2 banks).
    logic [7:0] mem1 [4][16];
    logic [7:0] mem2 [4][16];
    logic [7:0] rd1  [4];
    logic [7:0] rd2a [4];
    logic [7:0] rd2b [4];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus1.bank_en[b]) begin
                if (bus1.bank_we[b]) begin
                    mem1[b][bus1.bank_addr] <= bus1.bank_wdata;
                    rd1[b] <= bus1.bank_wdata;
                end else begin
                    rd1[b] <= mem1[b][bus1.bank_addr];
                end
            end
            if (bus2.bank_en[b]) begin
                if (bus2.bank_we[b]) begin
                    mem2[b][bus2.bank_addr] <= bus2.bank_wdata;
                    rd2a[b] <= bus2.bank_wdata;
                end else begin
                    rd2a[b] <= mem2[b][bus2.bank_addr];
                end
            end
            rd2b[b] <= rd2a[b];
        end
    end

    wire [7:0] mux1 = rd1[bus1.sel];
    wire [7:0] mux2 = rd2b[bus2.sel];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic we, input logic [AWF-1:0] addr,
                           input logic [7:0] wd);
        req_we[r]                = we;
        req_addr[r*AWF +: AWF]   = addr;
        req_wdata[r*8 +: 8]      = wd;
        req[r]                   = 1'b1;
        $display("[%0t] req%0d %s addr=0x%02h wdata=0x%02h", $time, r, we ? "WR" : "RD", addr, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [AWF-1:0] t5_addr [3];
    logic [1:0]     t5_bank [3];
    logic [7:0]     t5_data [3];
    int exp_r;
    int waited;

    initial begin
        t5_addr = '{6'h00, 6'h3F, 6'h17};
        t5_bank = '{2'd0, 2'd3, 2'd1};
        t5_data = '{8'h00, 8'h96, 8'h3C};
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        // ---------------- reset state, request held through INIT
        for (int r = 0; r < NR; r++) set_req(r, 1'b0, 6'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_bank_en", bus1.bank_en, 4'h0);
        check_eq("rst_bank_we", bus1.bank_we, 4'h0);
        check_eq("rst_bank_addr", bus1.bank_addr, 4'h0);
        check_eq("rst_rvalid", bus1.rvalid, 1'b0);
        check_eq("rst_rid", bus1.rid, 2'd0);
        check_eq("rst_sel", bus1.sel, 2'd0);
        check_eq("rst_init_done", bus1.init_done, 1'b0);
        check_eq("rst_gnt", bus1.gnt, 4'h0);
        rst = 1'b0;

        // ---------------- zero-fill: 16 cycles of full-width writes
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check_eq("fill_en", bus1.bank_en, 4'hF);
            check_eq("fill_we", bus1.bank_we, 4'hF);
            check_eq("fill_addr", bus1.bank_addr, 32'(c));
            check_eq("fill_wdata", bus1.bank_wdata, 8'h00);
            check_eq("fill_addr_lat2", bus2.bank_addr, 32'(c));
            check_eq("fill_init_done", bus1.init_done, 1'b0);
            check_eq("fill_gnt", bus1.gnt, 4'h0);
            if (c == 14) req = '0;
        end
        @(negedge clk);
        check_eq("init_done", bus1.init_done, 1'b1);
        check_eq("idle_bank_en", bus1.bank_en, 4'h0);

        // ---------------- single write then read, bank 2 addr 3
        set_req(0, 1'b1, 6'h23, 8'hA5);
        #1 check_eq("wr_gnt", bus1.gnt, 4'b0001);
        @(posedge clk); #1;
        set_req(0, 1'b0, 6'h23, 8'h00);
        @(negedge clk);
        check_eq("wr_bank_en", bus1.bank_en, 4'b0100);
        check_eq("wr_bank_we", bus1.bank_we, 4'b0100);
        check_eq("wr_bank_addr", bus1.bank_addr, 4'h3);
        check_eq("wr_bank_wdata", bus1.bank_wdata, 8'hA5);
        check_eq("rd_gnt", bus1.gnt, 4'b0001);
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        check_eq("rd_bank_en", bus1.bank_en, 4'b0100);
        check_eq("rd_bank_we", bus1.bank_we, 4'b0000);
        check_eq("rd_rvalid_early", bus1.rvalid, 1'b0);
        @(negedge clk);
        check_eq("rd_rvalid", bus1.rvalid, 1'b1);
        check_eq("rd_rid", bus1.rid, 2'd0);
        check_eq("rd_sel", bus1.sel, 2'd2);
        check_eq("rd_data", mux1, 8'hA5);
        check_eq("rd_rvalid_lat2_early", bus2.rvalid, 1'b0);
        @(negedge clk);
        check_eq("rd_rvalid_end", bus1.rvalid, 1'b0);
        check_eq("rd_sel_hold", bus1.sel, 2'd2);
        check_eq("rd_rvalid_lat2", bus2.rvalid, 1'b1);
        check_eq("rd_sel_lat2", bus2.sel, 2'd2);
        check_eq("rd_data_lat2", mux2, 8'hA5);

        // ---------------- round robin, all four reading (pointer starts at 1)
        for (int r = 0; r < NR; r++) set_req(r, 1'b0, 6'(r*16 + 3), 8'h00);
        #1 check_eq("rr_gnt_first", bus1.gnt, 4'b0010);
        for (int t = 0; t < 8; t++) begin
            @(posedge clk);
            if (t == 7) begin #1 req = '0; end
            @(negedge clk);
            if (t < 7) check_eq("rr_gnt", bus1.gnt, 32'(1 << ((t + 2) % 4)));
            if (t >= 1) begin
                exp_r = t % 4;
                check_eq("rr_rvalid", bus1.rvalid, 1'b1);
                check_eq("rr_rid", bus1.rid, 32'(exp_r));
                check_eq("rr_data", mux1, (exp_r == 2) ? 8'hA5 : 8'h00);
            end
            if (t >= 2) begin
                exp_r = (t - 1) % 4;
                check_eq("rr_rvalid_lat2", bus2.rvalid, 1'b1);
                check_eq("rr_rid_lat2", bus2.rid, 32'(exp_r));
                check_eq("rr_data_lat2", mux2, (exp_r == 2) ? 8'hA5 : 8'h00);
            end
        end
        repeat (3) @(negedge clk);
        check_eq("rr_drain", bus1.rvalid, 1'b0);
        check_eq("rr_drain_lat2", bus2.rvalid, 1'b0);

        // ---------------- pointer skip/wrap: move pointer to 3 via req2
        set_req(2, 1'b1, 6'h3F, 8'h96);
        #1 check_eq("ptr_setup_gnt", bus1.gnt, 4'b0100);
        @(posedge clk); #1 req = '0;
        set_req(1, 1'b1, 6'h17, 8'h3C);
        set_req(2, 1'b1, 6'h2A, 8'h77);
        #1 check_eq("wrap_gnt_req1", bus1.gnt, 4'b0010);
        @(posedge clk); #1 req[1] = 1'b0;
        check_eq("wrap_gnt_req2", bus1.gnt, 4'b0100);
        check_eq("wrap_we_req1", bus1.bank_we, 4'b0010);
        check_eq("wrap_addr_req1", bus1.bank_addr, 4'h7);
        @(posedge clk); #1 req = '0;
        check_eq("wrap_we_req2", bus1.bank_we, 4'b0100);
        check_eq("wrap_addr_req2", bus1.bank_addr, 4'hA);
        check_eq("wrap_wdata_req2", bus1.bank_wdata, 8'h77);
        @(negedge clk);
        check_eq("wr_no_rvalid", bus1.rvalid, 1'b0);
        check_eq("idle_addr_hold", bus1.bank_addr, 4'hA);

        // ---------------- back-to-back reads to banks 0,3,1
        set_req(3, 1'b0, t5_addr[0], 8'h00);
        #1 check_eq("b2b_gnt", bus1.gnt, 4'b1000);
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            if (t < 2) set_req(3, 1'b0, t5_addr[t+1], 8'h00);
            else if (t == 2) req = '0;
            @(negedge clk);
            if (t >= 1 && t <= 3) begin
                check_eq("b2b_rvalid", bus1.rvalid, 1'b1);
                check_eq("b2b_sel", bus1.sel, 32'(t5_bank[t-1]));
                check_eq("b2b_rid", bus1.rid, 2'd3);
                check_eq("b2b_data", mux1, 32'(t5_data[t-1]));
            end else begin
                check_eq("b2b_rvalid_off", bus1.rvalid, 1'b0);
            end
            if (t >= 2 && t <= 4) begin
                check_eq("b2b_rvalid_lat2", bus2.rvalid, 1'b1);
                check_eq("b2b_sel_lat2", bus2.sel, 32'(t5_bank[t-2]));
                check_eq("b2b_rid_lat2", bus2.rid, 2'd3);
                check_eq("b2b_data_lat2", mux2, 32'(t5_data[t-2]));
            end else begin
                check_eq("b2b_rvalid_lat2_off", bus2.rvalid, 1'b0);
            end
        end

        // ---------------- reset with two reads in flight
        set_req(0, 1'b0, 6'h23, 8'h00);
        set_req(1, 1'b0, 6'h3F, 8'h00);
        #1 check_eq("mid_gnt0", bus1.gnt, 4'b0001);
        @(posedge clk); #1 req[0] = 1'b0;
        check_eq("mid_gnt1", bus1.gnt, 4'b0010);
        @(posedge clk); #1 req = '0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rvalid", bus1.rvalid, 1'b0);
        check_eq("mid_rvalid_lat2", bus2.rvalid, 1'b0);
        check_eq("mid_init_done", bus1.init_done, 1'b0);
        @(negedge clk);
        check_eq("mid_rvalid2_lat2", bus2.rvalid, 1'b0);
        check_eq("refill_en", bus1.bank_en, 4'hF);
        check_eq("refill_addr", bus1.bank_addr, 4'h0);
        waited = 0;
        while (!bus1.init_done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_eq("refill_done", bus1.init_done, 1'b1);

        // Pointer back at 0: req1 wins over req2.
        set_req(1, 1'b0, 6'h17, 8'h00);
        set_req(2, 1'b0, 6'h2A, 8'h00);
        #1 check_eq("ptr_after_rst", bus1.gnt, 4'b0010);
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("refill_rvalid", bus1.rvalid, 1'b1);
        check_eq("refill_rid", bus1.rid, 2'd1);
        check_eq("refill_data", mux1, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_bank_arbiter.md
Name: bram_bank_arbiter

Overview:
Shares the four 8-bit BRAM banks between NUM_REQ requesters: one access per cycle, round-robin arbitration.
- Upper SELECT bits of each request address pick the bank; lower bits form the shared bank address.
- Generates per-bank enables and write strobes, and drives the bank-select into the output mux, delayed to align with BRAM read latency.
- Tags each read return with a requester id.
- After reset, zero-fills every bank word before granting any request.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BANK_AW, 10, per-bank address width; full request address width = BANK_AW+`SELECT
READ_LAT, 1, BRAM read latency in cycles (1 or 2)
INIT_EN, 1, 1 = zero-fill all banks after reset; 0 = go straight to READY

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request, held until granted
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*(BANK_AW+`SELECT)  packed addresses, requester i at slice i
req_wdata  in  NUM_REQ*8  packed write data
gnt  out  NUM_REQ  one-hot, combinational; req[i]&gnt[i] = accepted at this edge
bank_en  out  4  registered per-bank enable
bank_we  out  4  registered per-bank write strobe
bank_addr  out  BANK_AW  registered shared bank address
bank_wdata  out  8  registered shared write data
sel  out  `SELECT  registered bank select to the output mux, aligned with returning data
rvalid  out  1  registered; mux output is valid read data this cycle
rid  out  $clog2(NUM_REQ)  registered requester id of the returning read
init_done  out  1  registered; high once zero-fill is complete

Behaviour:
- Reset values:
  - All outputs 0: gnt, bank_en, bank_we, bank_addr, bank_wdata, sel, rvalid, rid, init_done.
  - RR pointer = 0, FSM = INIT (or READY if INIT_EN=0), fill counter = 0.
- FSM states:
  - INIT: each cycle bank_en=bank_we=4'b1111, bank_wdata=0, bank_addr=counter; counter increments. On the cycle bank_addr = 2^BANK_AW-1 is issued, go to READY; init_done rises the following cycle. gnt = 0 throughout INIT.
  - READY: arbitrate every cycle. There is no other state.
- Arbitration (READY):
  - Grant the first asserted req at or after the pointer, wrapping at NUM_REQ-1 -> 0.
  - On acceptance of requester i, pointer <= (i+1) mod NUM_REQ; no acceptance leaves the pointer unchanged.
  - gnt is 0 when no req is asserted.
- Issue, at the acceptance edge:
  - Bank b = addr[MSBs of width `SELECT]: bank_en = one-hot(b), bank_we = one-hot(b) & we, bank_addr = addr low bits, bank_wdata = wdata.
  - With no acceptance, bank_en and bank_we are 0 next cycle.
  - bank_addr and bank_wdata hold their last values when idle.
- Read return:
  - A read accepted at edge k has rvalid=1, rid=i and sel=b during the cycle after edge k+READ_LAT. That is, the response appears 1+READ_LAT cycles after acceptance; the mux output is then valid.
  - sel holds its last value when rvalid=0.
  - The (valid, sel, id) pipeline is READ_LAT+1 deep and fully pipelined: back-to-back reads, including reads to the same bank, return on consecutive cycles in acceptance order.
  - Writes produce no rvalid.
- Simultaneous events:
  - Read and write from different requesters: only one is granted per cycle.
  - A write followed by a read of the same address on the next edge returns the new data; the bank is in write-first or read-after-write order, one issue per cycle.
- Requester rules:
  - req_addr, req_we and req_wdata must be stable while req=1 and gnt=0.
  - Deasserting req before grant withdraws the request; no side effects.
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid after the reset edge.
  - Pointer returns to 0 and INIT restarts from address 0.
- Width rule: the address MSB slice is exactly `SELECT bits; bank index values 0..3 all map to a bank, with no out-of-range case.

Decomposition:
- Shared package package_fpga.v:
  - `SELECT (2) and the bank count (4).
  - Data width constant (8).
  - FSM state encodings INIT/READY.
- Sub-module rr_arbiter (NUM_REQ): inputs req and pointer, outputs one-hot gnt and granted index, purely combinational.
- Fill counter, issue registers and return pipeline stay in bram_bank_arbiter.

Test Plan:
- Zero-fill (BANK_AW=4, INIT_EN=1): release rst.
  - 16 cycles of bank_en=bank_we=1111 with bank_addr 0..15, wdata 0.
  - init_done=1 on cycle 17; gnt stays 0 while req is held during INIT.
- Single write then read (READ_LAT=1): req0 writes 0xA5 to addr {2'b10, 0x3}; then req0 reads the same address.
  - Write issues bank_en=0100, bank_we=0100, bank_addr=3.
  - Read has rvalid=1, rid=0, sel=2'b10 two cycles after acceptance; mux out = 0xA5.
- Round-robin fairness: all four req held continuously, all reads.
  - Grant order 0,1,2,3,0,1…; rid sequence matches, one rvalid per cycle with no gaps.
- Pointer skip/wrap: pointer at 3, only req1 and req2 asserted -> gnt = req1 first, then req2.
- READ_LAT=2: back-to-back reads to banks 0,3,1 -> rvalid for 3 consecutive cycles starting 3 cycles after the first acceptance, sel = 0,3,1.
- Reset mid-flight: assert rst one cycle after two reads are accepted.
  - No rvalid afterwards; pointer = 0; INIT restarts at bank_addr 0.
